addr_counter: RTL and testbench

Parametrised address/sequence counter for BRAM access and general event counting. It is the next generation of the team's free-running 8-bit counter, adding:
- width and programmable limit (modulo-N)
- up/down counting and parallel load
- wrap, one-shot and ping-pong modes
- clock-enable prescaler, terminal-count pulse and done flag

It sits between control logic and a BRAM address port, or drives LED/pattern sequencers directly.

---
 rtl/counter_pkg.sv | 11 +
 rtl/addr_counter_if.sv | 26 ++
 rtl/tick_divider.sv | 43 ++++
 rtl/addr_counter.sv | 155 +++++++++++++++
 tb/tb_addr_counter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the address/sequence counter: mode and direction encodings.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/addr_counter_if.sv
// Control/status bundle between a counter master (control logic) and addr_counter.
interface addr_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output en, dir, mode, limit, load, load_val,
    input  count, tc, done
  );

  modport slave (
    input  en, dir, mode, limit, load, load_val,
    output count, tc, done
  );

endinterface

// File: rtl/tick_divider.sv
// Enable prescaler: counts enabled cycles 0..DIV-1 and flags the last one as a tick.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (DIV == 1) begin : g_passthru
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst, en, clr};
      assign tick     = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(DIV);
      localparam logic [CW-1:0] LAST = CW'(DIV - 1);
      logic [CW-1:0] cnt_r;

      // Enabled-cycle counter; clr restarts the step period on a parallel load
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_r <= {CW{1'b0}};
        end else if (clr) begin
          cnt_r <= {CW{1'b0}};
        end else if (en) begin
          if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end else begin
          cnt_r <= cnt_r;
        end
      end

      assign tick = (cnt_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/addr_counter.sv
// Modulo-N up/down address counter with wrap, one-shot and ping-pong modes,
// parallel load, enable prescaler, terminal-count pulse and sticky done flag.
module addr_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input logic           clk,
  input logic           rst,
  addr_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             done_r;
  logic             pp_down_r;

  logic             tick_s;
  logic             step_s;
  logic [WIDTH-1:0] load_min_s;
  logic [WIDTH-1:0] cnt_p1_s;
  logic [WIDTH-1:0] cnt_m1_s;
  logic [WIDTH-1:0] lim_m1_s;
  logic [WIDTH-1:0] next_count_s;
  logic             next_tc_s;
  logic             next_done_s;
  logic             next_pp_down_s;

  tick_divider #(
    .DIV (PRESCALE)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick_s)
  );

  assign step_s     = bus.en & tick_s;
  assign load_min_s = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
  assign cnt_p1_s   = count_r + ONE;
  assign cnt_m1_s   = count_r - ONE;
  assign lim_m1_s   = bus.limit - ONE;

  // Next count, tc and direction for one step in the currently selected mode
  always_comb begin
    next_count_s   = count_r;
    next_tc_s      = 1'b0;
    next_done_s    = done_r;
    next_pp_down_s = pp_down_r;
    case (bus.mode)
      MODE_ONESHOT: begin
        if (done_r) begin
          next_count_s = count_r;
        end else if (bus.dir == DIR_UP) begin
          // An out-of-range count counts as already at the endpoint
          if ((count_r >= bus.limit) || (cnt_p1_s == bus.limit)) begin
            next_count_s = bus.limit;
            next_tc_s    = 1'b1;
            next_done_s  = 1'b1;
          end else begin
            next_count_s = cnt_p1_s;
          end
        end else begin
          if (count_r <= ONE) begin
            next_count_s = ZERO;
            next_tc_s    = 1'b1;
            next_done_s  = 1'b1;
          end else begin
            next_count_s = cnt_m1_s;
          end
        end
      end
      MODE_PINGPONG: begin
        if (bus.limit == ZERO) begin
          next_count_s = ZERO;
          next_tc_s    = 1'b1;
        end else if (!pp_down_r) begin
          if (count_r >= bus.limit) begin
            next_count_s   = lim_m1_s;
            next_pp_down_s = 1'b1;
            next_tc_s      = 1'b1;
          end else if (cnt_p1_s == bus.limit) begin
            next_count_s   = cnt_p1_s;
            next_pp_down_s = 1'b1;
            next_tc_s      = 1'b1;
          end else begin
            next_count_s = cnt_p1_s;
          end
        end else begin
          if (count_r == ZERO) begin
            next_count_s   = ONE;
            next_pp_down_s = 1'b0;
            next_tc_s      = 1'b1;
          end else if (count_r == ONE) begin
            next_count_s   = ZERO;
            next_pp_down_s = 1'b0;
            next_tc_s      = 1'b1;
          end else begin
            next_count_s = cnt_m1_s;
          end
        end
      end
      default: begin
        // Wrap mode; the reserved encoding also lands here
        if (bus.dir == DIR_UP) begin
          if (count_r >= bus.limit) begin
            next_count_s = ZERO;
            next_tc_s    = 1'b1;
          end else begin
            next_count_s = cnt_p1_s;
          end
        end else begin
          if (count_r == ZERO) begin
            next_count_s = bus.limit;
            next_tc_s    = 1'b1;
          end else begin
            next_count_s = cnt_m1_s;
          end
        end
      end
    endcase
  end

  // State registers: reset beats load, load beats step; tc is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r   <= ZERO;
      tc_r      <= 1'b0;
      done_r    <= 1'b0;
      pp_down_r <= 1'b0;
    end else if (bus.load) begin
      count_r   <= load_min_s;
      tc_r      <= 1'b0;
      done_r    <= 1'b0;
      pp_down_r <= 1'b0;
    end else if (step_s) begin
      count_r   <= next_count_s;
      tc_r      <= next_tc_s;
      done_r    <= next_done_s;
      pp_down_r <= next_pp_down_s;
    end else begin
      tc_r      <= 1'b0;
    end
  end

  assign bus.count = count_r;
  assign bus.tc    = tc_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_addr_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model,
// driving a PRESCALE=1 and a PRESCALE=4 counter with identical stimulus.
module tb_addr_counter;
  import counter_pkg::*;

  typedef struct {
    int count;
    bit tc;
    bit done;
    bit up;
    int pre;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  mstate_t m1;
  mstate_t m4;

  addr_counter_if #(.WIDTH(8)) b1 ();
  addr_counter_if #(.WIDTH(8)) b4 ();

  addr_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  addr_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  // Behavioural reference: one clock edge of the counter, in plain integer arithmetic
  function automatic mstate_t model_next(mstate_t s, bit r, bit e, bit d, bit [1:0] md,
                                         int lim, bit ld, int lv, int presc);
    mstate_t n = s;
    n.tc = 1'b0;
    if (r) begin
      n.count = 0; n.done = 1'b0; n.up = 1'b1; n.pre = 0;
    end else if (ld) begin
      n.count = (lv > lim) ? lim : lv; n.done = 1'b0; n.up = 1'b1; n.pre = 0;
    end else if (e) begin
      if (s.pre != presc - 1) begin
        n.pre = s.pre + 1;
      end else begin
        n.pre = 0;
        if (md == 2'd1) begin
          if (!s.done) begin
            if (!d) begin
              if (s.count + 1 >= lim) begin n.count = lim; n.tc = 1'b1; n.done = 1'b1; end
              else n.count = s.count + 1;
            end else begin
              if (s.count <= 1) begin n.count = 0; n.tc = 1'b1; n.done = 1'b1; end
              else n.count = s.count - 1;
            end
          end
        end else if (md == 2'd2) begin
          if (lim == 0) begin
            n.count = 0; n.tc = 1'b1;
          end else if (s.up) begin
            if (s.count >= lim) begin n.count = lim - 1; n.up = 1'b0; n.tc = 1'b1; end
            else begin
              n.count = s.count + 1;
              if (n.count == lim) begin n.up = 1'b0; n.tc = 1'b1; end
            end
          end else begin
            if (s.count == 0) begin n.count = 1; n.up = 1'b1; n.tc = 1'b1; end
            else begin
              n.count = s.count - 1;
              if (n.count == 0) begin n.up = 1'b1; n.tc = 1'b1; end
            end
          end
        end else begin
          if (!d) begin
            if (s.count >= lim) begin n.count = 0; n.tc = 1'b1; end
            else n.count = s.count + 1;
          end else begin
            if (s.count == 0) begin n.count = lim; n.tc = 1'b1; end
            else n.count = s.count - 1;
          end
        end
      end
    end
    return n;
  endfunction

  // Drive one cycle of inputs to both counters, advance the models, settle past the edge
  task automatic tick(input logic r, input logic e, input logic d, input logic [1:0] md,
                      input logic [7:0] lim, input logic ld, input logic [7:0] lv);
    rst = r;
    b1.en = e; b1.dir = d; b1.mode = md; b1.limit = lim; b1.load = ld; b1.load_val = lv;
    b4.en = e; b4.dir = d; b4.mode = md; b4.limit = lim; b4.load = ld; b4.load_val = lv;
    @(posedge clk);
    m1 = model_next(m1, r, e, d, md, int'(lim), ld, int'(lv), 1);
    m4 = model_next(m4, r, e, d, md, int'(lim), ld, int'(lv), 4);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0, MODE_WRAP, 8'd5, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 1'b1, MODE_ONESHOT, 8'd3, 1'b0, 8'd2);
    checks++;
    if (b1.count !== 8'd0 || b1.tc !== 1'b0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_p1 count=%0d tc=%0b done=%0b expected 0 0 0", b1.count, b1.tc, b1.done);
    end
    checks++;
    if (b4.count !== 8'd0 || b4.tc !== 1'b0 || b4.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_p4 count=%0d tc=%0b done=%0b expected 0 0 0", b4.count, b4.tc, b4.done);
    end
  endtask

  task automatic test_wrap_up();
    tick(1'b1, 1'b0, 1'b0, MODE_WRAP, 8'd5, 1'b0, 8'd0);
    for (int i = 0; i < 14; i++) begin
      int exp_c;
      exp_c = (i + 1) % 6;
      tick(1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd5, 1'b0, 8'd0);
      checks++;
      if (b1.count !== 8'(exp_c) || b1.tc !== (exp_c == 0)) begin
        errors++;
        $display("FAIL wrap_up step %0d count=%0d tc=%0b expected %0d %0b",
                 i, b1.count, b1.tc, exp_c, exp_c == 0);
      end
    end
  endtask

  task automatic test_down_load();
    int exp_c[4] = '{1, 0, 5, 4};
    tick(1'b0, 1'b0, 1'b1, MODE_WRAP, 8'd5, 1'b1, 8'd2);
    checks++;
    if (b1.count !== 8'd2 || b1.tc !== 1'b0) begin
      errors++;
      $display("FAIL down_load_val count=%0d tc=%0b expected 2 0", b1.count, b1.tc);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b1, MODE_WRAP, 8'd5, 1'b0, 8'd0);
      checks++;
      if (b1.count !== 8'(exp_c[i]) || b1.tc !== (exp_c[i] == 5)) begin
        errors++;
        $display("FAIL down_wrap step %0d count=%0d tc=%0b expected %0d %0b",
                 i, b1.count, b1.tc, exp_c[i], exp_c[i] == 5);
      end
    end
  endtask

  task automatic test_oneshot();
    tick(1'b1, 1'b0, 1'b0, MODE_ONESHOT, 8'd3, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      int exp_c;
      exp_c = (i < 2) ? i + 1 : 3;
      tick(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 8'd3, 1'b0, 8'd0);
      checks++;
      if (b1.count !== 8'(exp_c) || b1.tc !== (i == 2) || b1.done !== (i >= 2)) begin
        errors++;
        $display("FAIL oneshot step %0d count=%0d tc=%0b done=%0b expected %0d %0b %0b",
                 i, b1.count, b1.tc, b1.done, exp_c, i == 2, i >= 2);
      end
    end
    tick(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 8'd3, 1'b1, 8'd0);
    checks++;
    if (b1.count !== 8'd0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload count=%0d done=%0b expected 0 0", b1.count, b1.done);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 8'd3, 1'b0, 8'd0);
      checks++;
      if (b1.count !== 8'(i + 1) || b1.done !== (i == 2)) begin
        errors++;
        $display("FAIL oneshot_restart step %0d count=%0d done=%0b expected %0d %0b",
                 i, b1.count, b1.done, i + 1, i == 2);
      end
    end
  endtask

  task automatic test_pingpong();
    int exp_c[9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
    tick(1'b1, 1'b0, 1'b0, MODE_PINGPONG, 8'd3, 1'b0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1, i[0], MODE_PINGPONG, 8'd3, 1'b0, 8'd0);
      checks++;
      if (b1.count !== 8'(exp_c[i]) || b1.tc !== (exp_c[i] == 3 || exp_c[i] == 0)) begin
        errors++;
        $display("FAIL pingpong step %0d count=%0d tc=%0b expected %0d %0b",
                 i, b1.count, b1.tc, exp_c[i], exp_c[i] == 3 || exp_c[i] == 0);
      end
    end
  endtask

  task automatic test_prescale();
    bit en_pat[9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    int exp4[9]   = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    int exp1[9]   = '{1, 2, 2, 3, 4, 5, 0, 1, 2};
    tick(1'b1, 1'b0, 1'b0, MODE_WRAP, 8'd5, 1'b0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, en_pat[i], 1'b0, MODE_WRAP, 8'd5, 1'b0, 8'd0);
      checks++;
      if (b4.count !== 8'(exp4[i]) || b4.tc !== 1'b0) begin
        errors++;
        $display("FAIL prescale4 cyc %0d count=%0d tc=%0b expected %0d 0", i, b4.count, b4.tc, exp4[i]);
      end
      checks++;
      if (b1.count !== 8'(exp1[i]) || b1.tc !== (en_pat[i] && exp1[i] == 0)) begin
        errors++;
        $display("FAIL enable_freeze cyc %0d count=%0d tc=%0b expected %0d", i, b1.count, b1.tc, exp1[i]);
      end
    end
  endtask

  task automatic test_edges();
    tick(1'b1, 1'b1, 1'b0, MODE_WRAP, 8'd7, 1'b1, 8'd4);
    checks++;
    if (b1.count !== 8'd0 || b4.count !== 8'd0) begin
      errors++;
      $display("FAIL rst_over_load count=%0d/%0d expected 0", b1.count, b4.count);
    end
    tick(1'b0, 1'b0, 1'b0, MODE_WRAP, 8'd5, 1'b1, 8'd9);
    checks++;
    if (b1.count !== 8'd5) begin
      errors++;
      $display("FAIL load_clamp count=%0d expected 5", b1.count);
    end
    tick(1'b0, 1'b0, 1'b0, MODE_WRAP, 8'd7, 1'b1, 8'd6);
    tick(1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd2, 1'b0, 8'd0);
    checks++;
    if (b1.count !== 8'd0 || b1.tc !== 1'b1) begin
      errors++;
      $display("FAIL limit_lowered count=%0d tc=%0b expected 0 1", b1.count, b1.tc);
    end
    tick(1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd0, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 1'b0, MODE_WRAP, 8'd0, 1'b0, 8'd0);
    checks++;
    if (b1.count !== 8'd0 || b1.tc !== 1'b1) begin
      errors++;
      $display("FAIL limit_zero count=%0d tc=%0b expected 0 1", b1.count, b1.tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic r, e, d, ld;
      logic [1:0] md;
      logic [7:0] lim, lv;
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 19) == 0);
      md  = 2'($urandom_range(0, 3));
      lim = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      lv  = 8'($urandom_range(0, 20));
      tick(r, e, d, md, lim, ld, lv);
      checks++;
      if (b1.count !== 8'(m1.count) || b1.tc !== m1.tc || b1.done !== m1.done) begin
        errors++;
        $display("FAIL random_p1 cyc %0d count=%0d tc=%0b done=%0b expected %0d %0b %0b",
                 i, b1.count, b1.tc, b1.done, m1.count, m1.tc, m1.done);
      end
      checks++;
      if (b4.count !== 8'(m4.count) || b4.tc !== m4.tc || b4.done !== m4.done) begin
        errors++;
        $display("FAIL random_p4 cyc %0d count=%0d tc=%0b done=%0b expected %0d %0b %0b",
                 i, b4.count, b4.tc, b4.done, m4.count, m4.tc, m4.done);
      end
    end
  endtask

  initial begin
    m1 = '{count: 0, tc: 1'b0, done: 1'b0, up: 1'b1, pre: 0};
    m4 = '{count: 0, tc: 1'b0, done: 1'b0, up: 1'b1, pre: 0};
    test_reset();
    test_wrap_up();
    test_down_load();
    test_oneshot();
    test_pingpong();
    test_prescale();
    test_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
